// File: rtl/uart_rx_if.sv
// uart_rx output bundle: received byte plus status strobes.
// master drives it (the receiver), slave observes it.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output frame_error,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input frame_error,
    input busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, LSB first.
// One-cycle valid per good frame, frame_error on a low stop bit.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master rxb
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] THALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] ILAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sync            <= 2'b11;
      timer           <= '0;
      idx             <= '0;
      shreg           <= '0;
      rxb.data        <= '0;
      rxb.valid       <= 1'b0;
      rxb.frame_error <= 1'b0;
      rxb.busy        <= 1'b0;
    end else begin
      sync            <= {sync[0], rx};
      rxb.valid       <= 1'b0;
      rxb.frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            timer    <= '0;
            rxb.busy <= 1'b1;
          end
        end
        START: begin
          if (timer == THALF) begin
            timer <= '0;
            if (rx_s) begin
              state    <= IDLE;
              rxb.busy <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == TLAST) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == ILAST) state <= STOP;
            else idx <= idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          // leave mid-stop-bit so a following start edge is never missed
          if (timer == TLAST) begin
            timer <= '0;
            if (rx_s) begin
              rxb.data  <= shreg;
              rxb.valid <= 1'b1;
              rxb.busy  <= 1'b0;
              state     <= IDLE;
            end else begin
              rxb.frame_error <= 1'b1;
              state           <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state    <= IDLE;
            rxb.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rxb.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: time-schedule reference model,
// per-cycle compare, plus literal scenario checks.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rxl = 2'b11;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) b0 ();
  uart_rx_if #(.DATA_BITS(8)) b1 ();

  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(32)) dut0 (
    .clk(clk), .rst(rst), .rx(rxl[0]), .rxb(b0)
  );
  uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(7)) dut1 (
    .clk(clk), .rst(rst), .rx(rxl[1]), .rxb(b1)
  );

  int tests = 0;
  int fails = 0;
  int nprint = 0;
  int cyc = 0;
  int rst_edge = 0;
  int last_fall = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, got, exp, cyc);
      end
    end
  endtask

  // reference model: frame timing computed from the falling-edge time
  logic rxh [2][0:99999];
  int   md  [2];
  int   t0  [2];
  logic [7:0] acc  [2];
  logic [7:0] e_d  [2];
  logic       e_v  [2];
  logic       e_f  [2];
  logic       e_b  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      md[d] = 0; t0[d] = 0; acc[d] = 0;
      e_d[d] = 0; e_v[d] = 0; e_f[d] = 0; e_b[d] = 0;
    end
  end

  function automatic logic rxs(input int d, input int n);
    if (n - 2 > rst_edge) return rxh[d][n-2];
    return 1'b1;
  endfunction

  task automatic step(input int d);
    int   c;
    int   h;
    int   off;
    int   k;
    logic rs;
    c = d ? 7 : 32;
    h = c / 2;
    rs = rxs(d, cyc);
    e_v[d] = 1'b0;
    e_f[d] = 1'b0;
    if (md[d] == 0) begin
      if (!rs) begin
        md[d] = 1; t0[d] = cyc; acc[d] = 0;
      end
    end else if (md[d] == 1) begin
      off = cyc - t0[d];
      if (off == h && rs) begin
        md[d] = 0;
      end else if (off > h && (off - h) % c == 0) begin
        k = (off - h) / c;
        if (k <= 8) begin
          acc[d][k-1] = rs;
        end else if (rs) begin
          e_v[d] = 1'b1; e_d[d] = acc[d]; md[d] = 0;
        end else begin
          e_f[d] = 1'b1; md[d] = 2;
        end
      end
    end else if (rs) begin
      md[d] = 0;
    end
    e_b[d] = (md[d] != 0);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    rxh[0][cyc] = rxl[0];
    rxh[1][cyc] = rxl[1];
    if (rst) begin
      rst_edge = cyc;
      for (int d = 0; d < 2; d++) begin
        md[d] = 0; e_d[d] = 0; e_v[d] = 0; e_f[d] = 0; e_b[d] = 0;
      end
    end else begin
      step(0);
      step(1);
    end
  end

  // per-cycle compare and scoreboard
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int vc0[$];
  int vc1[$];
  int fe0 = 0;
  int fe1 = 0;

  always @(negedge clk) begin
    chk("valid0", int'(b0.valid), int'(e_v[0]));
    chk("ferr0",  int'(b0.frame_error), int'(e_f[0]));
    chk("busy0",  int'(b0.busy), int'(e_b[0]));
    chk("data0",  int'(b0.data), int'(e_d[0]));
    chk("valid1", int'(b1.valid), int'(e_v[1]));
    chk("ferr1",  int'(b1.frame_error), int'(e_f[1]));
    chk("busy1",  int'(b1.busy), int'(e_b[1]));
    chk("data1",  int'(b1.data), int'(e_d[1]));
    if (b0.valid) begin q0.push_back(b0.data); vc0.push_back(cyc); end
    if (b1.valid) begin q1.push_back(b1.data); vc1.push_back(cyc); end
    if (b0.frame_error) fe0++;
    if (b1.frame_error) fe1++;
  end

  task automatic hold(input int d, input logic v, input int n);
    rxl[d] = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic sb);
    int c;
    c = d ? 7 : 32;
    last_fall = cyc;
    hold(d, 1'b0, c);
    for (int i = 0; i < 8; i++) hold(d, b[i], c);
    hold(d, sb, c);
  endtask

  task automatic clear();
    q0.delete(); q1.delete(); vc0.delete(); vc1.delete();
    fe0 = 0; fe1 = 0;
  endtask

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int xf0;
  int xf1;

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    hold(0, 1'b1, 10);
    chk("rst_data", int'(b0.data), 0);
    chk("rst_busy", int'(b0.busy), 0);

    clear();
    send(0, 8'h5C, 1'b1);
    hold(0, 1'b1, 40);
    chk("single_cnt", q0.size(), 1);
    if (q0.size() == 1) begin
      chk("single_data", int'(q0[0]), 8'h5C);
      chk("single_lat_ok",
          int'((vc0[0] - last_fall) >= 306 && (vc0[0] - last_fall) <= 307), 1);
    end
    chk("single_ferr", fe0, 0);

    clear();
    for (int i = 0; i < 8; i++) send(0, 8'(8'h5C + i), 1'b1);
    hold(0, 1'b1, 40);
    chk("b2b_cnt", q0.size(), 8);
    for (int i = 0; i < 8 && i < q0.size(); i++)
      chk("b2b_data", int'(q0[i]), 8'h5C + i);

    clear();
    hold(0, 1'b0, 8);
    hold(0, 1'b1, 40);
    chk("glitch_valid", q0.size(), 0);
    chk("glitch_ferr", fe0, 0);
    chk("glitch_busy", int'(b0.busy), 0);
    send(0, 8'hA5, 1'b1);
    hold(0, 1'b1, 40);
    chk("glitch_next_cnt", q0.size(), 1);
    if (q0.size() == 1) chk("glitch_next", int'(q0[0]), 8'hA5);

    clear();
    send(0, 8'h3C, 1'b0);
    hold(0, 1'b0, 100);
    chk("ferr_cnt", fe0, 1);
    chk("ferr_novalid", q0.size(), 0);
    chk("ferr_hold_data", int'(b0.data), 8'hA5);
    chk("ferr_busy_low_line", int'(b0.busy), 1);
    hold(0, 1'b1, 40);
    send(0, 8'h81, 1'b1);
    hold(0, 1'b1, 40);
    chk("ferr_next_cnt", q0.size(), 1);
    if (q0.size() == 1) chk("ferr_next", int'(q0[0]), 8'h81);

    clear();
    hold(0, 1'b0, 32 * 5);
    hold(0, 1'b1, 16);
    rst = 1'b1;
    hold(0, 1'b1, 1);
    rst = 1'b0;
    chk("rst_mid_busy", int'(b0.busy), 0);
    hold(0, 1'b1, 16 + 32 * 4 + 40);
    chk("rst_mid_valid", q0.size(), 0);
    chk("rst_mid_ferr", fe0, 0);
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    hold(0, 1'b1, 40);
    chk("rst_next_cnt", q0.size(), 2);
    if (q0.size() == 2) begin
      chk("rst_next0", int'(q0[0]), 8'h00);
      chk("rst_next1", int'(q0[1]), 8'hFF);
    end

    clear();
    send(1, 8'h55, 1'b1);
    hold(1, 1'b1, 10);
    chk("odd_lat_cnt", vc1.size(), 1);
    if (vc1.size() == 1) chk("odd_lat", vc1[0] - last_fall, 69);
    send(1, 8'hAA, 1'b1);
    hold(1, 1'b1, 10);
    chk("odd_cnt", q1.size(), 2);
    if (q1.size() == 2) begin
      chk("odd0", int'(q1[0]), 8'h55);
      chk("odd1", int'(q1[1]), 8'hAA);
    end

    clear();
    xf0 = 0;
    xf1 = 0;
    for (int n = 0; n < 24; n++) begin
      int d;
      int c;
      logic [7:0] b;
      d = int'($urandom_range(0, 1));
      c = d ? 7 : 32;
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0)
        hold(d, 1'b0, int'($urandom_range(1, c / 2 - 1)));
      hold(d, 1'b1, c + int'($urandom_range(0, 2 * c)));
      if ($urandom_range(0, 5) == 0) begin
        send(d, b, 1'b0);
        hold(d, 1'b0, int'($urandom_range(0, 50)));
        if (d == 0) xf0++; else xf1++;
      end else begin
        send(d, b, 1'b1);
        if (d == 0) exp0.push_back(b); else exp1.push_back(b);
      end
      hold(d, 1'b1, int'($urandom_range(0, 3)));
    end
    hold(0, 1'b1, 40);
    chk("rnd_cnt0", q0.size(), exp0.size());
    chk("rnd_cnt1", q1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < q0.size(); i++)
      chk("rnd_data0", int'(q0[i]), int'(exp0[i]));
    for (int i = 0; i < exp1.size() && i < q1.size(); i++)
      chk("rnd_data1", int'(q1[i]), int'(exp1[i]));
    chk("rnd_ferr0", fe0, xf0);
    chk("rnd_ferr1", fe1, xf1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
